bitrev_uart_engine: RTL

//  Parametrised successor to the 8-bit message printer. Collects ASCII '0'/'1' chars from UART RX

---
 rtl/bitrev_pkg.sv | 27 ++
 rtl/bitrev_word_fifo.sv | 51 +++++
 rtl/bitrev_uart_engine.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/bitrev_pkg.sv
// Shared constants, TX state encoding and the bit-reverse helper for the bitrev UART engine.
package bitrev_pkg;

   localparam logic [7:0] ASCII_0 = 8'h30;
   localparam logic [7:0] ASCII_1 = 8'h31;
   localparam int         MAX_WORD_BITS = 32;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      PAR,
      TERM
   } tx_state_t;

   // Reverses the low w bits of v; bits at and above w come back as zero.
   function automatic logic [MAX_WORD_BITS-1:0] bit_reverse(input logic [MAX_WORD_BITS-1:0] v,
                                                            input int w);
      logic [MAX_WORD_BITS-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_WORD_BITS; i++) begin
         if (i < w) r[5'(i)] = v[5'(w - 1 - i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/bitrev_word_fifo.sv
// Synchronous word FIFO; a push into a full FIFO succeeds only when a pop happens in the same cycle.
module bitrev_word_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (r_level == LW'(DEPTH));
   assign empty     = (r_level == '0);
   assign level     = r_level;
   assign dout      = r_mem[r_rd_ptr];
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
         else if (w_do_pop && !w_do_push) r_level <= r_level - 1'b1;
      end
   end

endmodule

// File: rtl/bitrev_uart_engine.sv
// Collects ASCII bit chars into words, optionally bit-reverses, queues them and replays them to UART TX.
// Define BITREV_PARITY_EN to append an even-parity char after each word's bits.
module bitrev_uart_engine
   import bitrev_pkg::*;
#(
   parameter int         WORD_BITS = 8,
   parameter int         DEPTH     = 4,
   parameter logic [7:0] TERM_CHAR = 8'h0A
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [7:0]                     rx_data,
   input  logic                           new_rx_data,
   input  logic                           rev_en,
   output logic [7:0]                     tx_data,
   output logic                           new_tx_data,
   input  logic                           tx_busy,
   output logic [$clog2(WORD_BITS+1)-1:0] bit_cnt,
   output logic [$clog2(DEPTH+1)-1:0]     fifo_level,
   output logic                           bad_char,
   output logic                           overflow,
   output tx_state_t                      dbg_state
);

   localparam int CNT_W = $clog2(WORD_BITS+1);
   localparam int IDX_W = $clog2(WORD_BITS);

   logic [WORD_BITS-1:0] r_word;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_bad;
   logic                 r_ovf;
   logic [WORD_BITS-1:0] r_shift;
   logic [IDX_W-1:0]     r_idx;
   logic                 r_strobe_d;
   logic [7:0]           r_tx_hold;
   tx_state_t            r_state;
   tx_state_t            w_next;
`ifdef BITREV_PARITY_EN
   logic                 r_par;
`endif

   logic                 w_is_bit;
   logic                 w_push;
   logic [WORD_BITS-1:0] w_push_data;
   logic [WORD_BITS-1:0] w_pop_data;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic                 w_tx_ok;
   logic                 w_strobe;
   logic [7:0]           w_char;

   assign w_is_bit    = new_rx_data && ((rx_data == ASCII_0) || (rx_data == ASCII_1));
   // A full count is visible for exactly one cycle: that cycle is the push.
   assign w_push      = (r_cnt == CNT_W'(WORD_BITS));
   assign w_push_data = rev_en ? WORD_BITS'(bit_reverse(32'(r_word), WORD_BITS)) : r_word;

   bitrev_word_fifo #(
      .WIDTH (WORD_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .din   (w_push_data),
      .pop   (w_pop),
      .dout  (w_pop_data),
      .full  (w_full),
      .empty (w_empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word <= '0;
         r_cnt  <= '0;
         r_bad  <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_bad <= new_rx_data && !w_is_bit;
         if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
         if (w_is_bit) begin
            r_word <= {r_word[WORD_BITS-2:0], rx_data[0]};
            r_cnt  <= w_push ? CNT_W'(1) : r_cnt + 1'b1;
         end else if (w_push) begin
            r_cnt <= '0;
         end
      end
   end

   // uart_tx raises busy a cycle late, so the cycle right after a strobe is never usable.
   assign w_tx_ok = !tx_busy && !r_strobe_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_pop    = 1'b0;
      w_strobe = 1'b0;
      w_char   = r_shift[WORD_BITS-1] ? ASCII_1 : ASCII_0;
      case (r_state)
         // Watching the push directly lets LOAD follow the push by one cycle; holding off
         // while busy keeps the head word in the FIFO so a stalled TX does not absorb a slot.
         IDLE: if ((!w_empty || w_push) && !tx_busy) w_next = LOAD;
         LOAD: begin
            w_pop  = 1'b1;
            w_next = SEND;
         end
         SEND: if (w_tx_ok) begin
            w_strobe = 1'b1;
`ifdef BITREV_PARITY_EN
            if (r_idx == IDX_W'(WORD_BITS-1)) w_next = PAR;
`else
            if (r_idx == IDX_W'(WORD_BITS-1)) w_next = TERM;
`endif
         end
`ifdef BITREV_PARITY_EN
         PAR: begin
            w_char = r_par ? ASCII_1 : ASCII_0;
            if (w_tx_ok) begin
               w_strobe = 1'b1;
               w_next   = TERM;
            end
         end
`endif
         TERM: begin
            w_char = TERM_CHAR;
            if (w_tx_ok) begin
               w_strobe = 1'b1;
               w_next   = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift    <= '0;
         r_idx      <= '0;
         r_strobe_d <= 1'b0;
         r_tx_hold  <= 8'h00;
`ifdef BITREV_PARITY_EN
         r_par      <= 1'b0;
`endif
      end else begin
         r_strobe_d <= w_strobe;
         if (w_strobe) r_tx_hold <= w_char;
         if (r_state == LOAD) begin
            r_shift <= w_pop_data;
            r_idx   <= '0;
`ifdef BITREV_PARITY_EN
            r_par   <= ^w_pop_data;
`endif
         end else if (w_strobe && (r_state == SEND)) begin
            r_shift <= r_shift << 1;
            r_idx   <= r_idx + 1'b1;
         end
      end
   end

   assign new_tx_data = w_strobe;
   assign tx_data     = w_strobe ? w_char : r_tx_hold;
   assign bit_cnt     = r_cnt;
   assign bad_char    = r_bad;
   assign overflow    = r_ovf;
   assign dbg_state   = r_state;

endmodule
